// File: rtl/nios_system_nios2_mul_pipe.sv
// -----------------------------------------------------------------------------
// nios_system_nios2_mul_pipe
//
// Pipelined DATA_W x DATA_W integer multiplier for the Nios II execute/memory
// path. Returns the fully assembled low or high word of the 2*DATA_W product,
// with signed, unsigned and mixed operand signedness selected by the op tag.
// A valid bit and the op tag travel with the data. The whole pipe freezes when
// i_en is low, and i_flush kills every in-flight operation.
//
// Parameters
//   DATA_W   operand/result width (even, 8..64)
//   LATENCY  cycles from accept to o_valid (1..4)
//
// Ports
//   i_clk     rising-edge clock (only clock)
//   i_reset   asynchronous active-high reset
//   i_en      pipeline advance; 0 holds every stage register
//   i_flush   clears every stage valid bit on the next edge
//   i_valid   operation presented this cycle
//   i_op      0=MUL (low), 1=MULH (s*s), 2=MULHSU (s*u), 3=MULHU (u*u)
//   i_src1    multiplicand
//   i_src2    multiplier
//   o_valid   result valid
//   o_op      op tag of the result
//   o_result  selected word of the product
//
// Stage map
//   LATENCY=1: output register <- full combinational product of the inputs
//   LATENCY=2: operands -> output
//   LATENCY=3: operands -> partial products -> output
//   LATENCY=4: operands -> partial products -> corrected product -> output
// -----------------------------------------------------------------------------
module nios_system_nios2_mul_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_src1,
    input  logic [DATA_W-1:0] i_src2,
    output logic              o_valid,
    output logic [1:0]        o_op,
    output logic [DATA_W-1:0] o_result
);

    localparam int H = DATA_W / 2;

    // ------------------------------------------------------------------
    // Operand stage (present when LATENCY >= 2)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_a_src1;
    logic [DATA_W-1:0] w_a_src2;
    logic [1:0]        w_a_op;
    logic              w_a_valid;

    generate
        if (LATENCY >= 2) begin : g_stage_a
            logic [DATA_W-1:0] r_src1;
            logic [DATA_W-1:0] r_src2;
            logic [1:0]        r_op;
            logic              r_valid;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_src1  <= '0;
                    r_src2  <= '0;
                    r_op    <= '0;
                    r_valid <= 1'b0;
                end else begin
                    // Flush wins over stall for the valid bit only.
                    if (i_flush)
                        r_valid <= 1'b0;
                    else if (i_en)
                        r_valid <= i_valid;
                    if (i_en) begin
                        r_src1 <= i_src1;
                        r_src2 <= i_src2;
                        r_op   <= i_op;
                    end
                end
            end

            assign w_a_src1  = r_src1;
            assign w_a_src2  = r_src2;
            assign w_a_op    = r_op;
            assign w_a_valid = r_valid;
        end else begin : g_no_stage_a
            assign w_a_src1  = i_src1;
            assign w_a_src2  = i_src2;
            assign w_a_op    = i_op;
            assign w_a_valid = i_valid;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Unsigned H x H partial products and the signed correction term
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_pll;
    logic [DATA_W-1:0] w_plh;
    logic [DATA_W-1:0] w_phl;
    logic [DATA_W-1:0] w_phh;
    logic              w_src1_neg;
    logic              w_src2_neg;
    logic [DATA_W-1:0] w_corr;

    assign w_pll = {{H{1'b0}}, w_a_src1[H-1:0]}      * {{H{1'b0}}, w_a_src2[H-1:0]};
    assign w_plh = {{H{1'b0}}, w_a_src1[H-1:0]}      * {{H{1'b0}}, w_a_src2[DATA_W-1:H]};
    assign w_phl = {{H{1'b0}}, w_a_src1[DATA_W-1:H]} * {{H{1'b0}}, w_a_src2[H-1:0]};
    assign w_phh = {{H{1'b0}}, w_a_src1[DATA_W-1:H]} * {{H{1'b0}}, w_a_src2[DATA_W-1:H]};

    // src1 is signed for MULH/MULHSU, src2 only for MULH.
    assign w_src1_neg = w_a_src1[DATA_W-1] & ((w_a_op == 2'd1) | (w_a_op == 2'd2));
    assign w_src2_neg = w_a_src2[DATA_W-1] & (w_a_op == 2'd1);

    // The correction is subtracted at bit DATA_W, so only its low DATA_W
    // bits can reach a 2*DATA_W product; its carry-out is dropped on purpose.
    assign w_corr = (w_src1_neg ? w_a_src2 : '0) + (w_src2_neg ? w_a_src1 : '0);

    // ------------------------------------------------------------------
    // Partial-product stage (present when LATENCY >= 3)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_b_pll;
    logic [DATA_W-1:0] w_b_plh;
    logic [DATA_W-1:0] w_b_phl;
    logic [DATA_W-1:0] w_b_phh;
    logic [DATA_W-1:0] w_b_corr;
    logic [1:0]        w_b_op;
    logic              w_b_valid;

    generate
        if (LATENCY >= 3) begin : g_stage_b
            logic [DATA_W-1:0] r_pll;
            logic [DATA_W-1:0] r_plh;
            logic [DATA_W-1:0] r_phl;
            logic [DATA_W-1:0] r_phh;
            logic [DATA_W-1:0] r_corr;
            logic [1:0]        r_op;
            logic              r_valid;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_pll   <= '0;
                    r_plh   <= '0;
                    r_phl   <= '0;
                    r_phh   <= '0;
                    r_corr  <= '0;
                    r_op    <= '0;
                    r_valid <= 1'b0;
                end else begin
                    if (i_flush)
                        r_valid <= 1'b0;
                    else if (i_en)
                        r_valid <= w_a_valid;
                    if (i_en) begin
                        r_pll  <= w_pll;
                        r_plh  <= w_plh;
                        r_phl  <= w_phl;
                        r_phh  <= w_phh;
                        r_corr <= w_corr;
                        r_op   <= w_a_op;
                    end
                end
            end

            assign w_b_pll   = r_pll;
            assign w_b_plh   = r_plh;
            assign w_b_phl   = r_phl;
            assign w_b_phh   = r_phh;
            assign w_b_corr  = r_corr;
            assign w_b_op    = r_op;
            assign w_b_valid = r_valid;
        end else begin : g_no_stage_b
            assign w_b_pll   = w_pll;
            assign w_b_plh   = w_plh;
            assign w_b_phl   = w_phl;
            assign w_b_phh   = w_phh;
            assign w_b_corr  = w_corr;
            assign w_b_op    = w_a_op;
            assign w_b_valid = w_a_valid;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Product assembly: phh and pll never overlap, so they concatenate.
    // The middle sum keeps its carry (DATA_W+1 bits).
    // ------------------------------------------------------------------
    logic [DATA_W:0]     w_mid;
    logic [2*DATA_W-1:0] w_prod;

    assign w_mid  = {1'b0, w_b_plh} + {1'b0, w_b_phl};
    assign w_prod = {w_b_phh, w_b_pll}
                  + ({{(DATA_W-1){1'b0}}, w_mid} << H)
                  - {w_b_corr, {DATA_W{1'b0}}};

    // ------------------------------------------------------------------
    // Corrected-product stage (present when LATENCY == 4)
    // ------------------------------------------------------------------
    logic [2*DATA_W-1:0] w_c_prod;
    logic [1:0]          w_c_op;
    logic                w_c_valid;

    generate
        if (LATENCY >= 4) begin : g_stage_c
            logic [2*DATA_W-1:0] r_prod;
            logic [1:0]          r_op;
            logic                r_valid;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_prod  <= '0;
                    r_op    <= '0;
                    r_valid <= 1'b0;
                end else begin
                    if (i_flush)
                        r_valid <= 1'b0;
                    else if (i_en)
                        r_valid <= w_b_valid;
                    if (i_en) begin
                        r_prod <= w_prod;
                        r_op   <= w_b_op;
                    end
                end
            end

            assign w_c_prod  = r_prod;
            assign w_c_op    = r_op;
            assign w_c_valid = r_valid;
        end else begin : g_no_stage_c
            assign w_c_prod  = w_prod;
            assign w_c_op    = w_b_op;
            assign w_c_valid = w_b_valid;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Word select and output register
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_sel;

    assign w_sel = (w_c_op == 2'd0) ? w_c_prod[DATA_W-1:0] : w_c_prod[2*DATA_W-1:DATA_W];

    logic              r_out_valid;
    logic [1:0]        r_out_op;
    logic [DATA_W-1:0] r_out_result;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_valid  <= 1'b0;
            r_out_op     <= '0;
            r_out_result <= '0;
        end else begin
            if (i_flush)
                r_out_valid <= 1'b0;
            else if (i_en)
                r_out_valid <= w_c_valid;
            if (i_en) begin
                r_out_op     <= w_c_op;
                r_out_result <= w_sel;
            end
        end
    end

    assign o_valid  = r_out_valid;
    assign o_op     = r_out_op;
    assign o_result = r_out_result;

endmodule

// File: tb/tb_nios_system_nios2_mul_pipe.sv
// -----------------------------------------------------------------------------
// Bench for nios_system_nios2_mul_pipe. Four instances (LATENCY 1..4, DATA_W 32)
// share one stimulus stream. A reference model holds, per instance, an ideal
// pipe of LATENCY slots of {valid, op, product word}; the product word is
// computed from plain 64-bit arithmetic at accept time.
// -----------------------------------------------------------------------------
module tb_nios_system_nios2_mul_pipe;

    localparam int DW = 32;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic          vin;
    logic [1:0]    op;
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;

    logic          w_v   [NL];
    logic [1:0]    w_op  [NL];
    logic [DW-1:0] w_res [NL];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_dut
            nios_system_nios2_mul_pipe #(
                .DATA_W (DW),
                .LATENCY(gi + 1)
            ) u_dut (
                .i_clk   (clk),
                .i_reset (rst),
                .i_en    (en),
                .i_flush (flush),
                .i_valid (vin),
                .i_op    (op),
                .i_src1  (s1),
                .i_src2  (s2),
                .o_valid (w_v[gi]),
                .o_op    (w_op[gi]),
                .o_result(w_res[gi])
            );
        end
    endgenerate

    // model slots: [instance][slot], slot == instance index is the output
    logic          m_v   [NL][NL];
    logic [1:0]    m_op  [NL][NL];
    logic [DW-1:0] m_res [NL][NL];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [DW-1:0] ref_mul(input logic [1:0] o, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'd0:    p = ua * ub;
            2'd1:    p = sa * sb;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input int inst, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s L=%0d: got %h expected %h", name, inst + 1, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++)
            for (int k = 0; k < NL; k++)
                m_v[i][k] = 1'b0;
    endtask

    task automatic check_all();
        for (int i = 0; i < NL; i++) begin
            chk("out_valid", i, {31'b0, w_v[i]}, {31'b0, m_v[i][i]});
            if (m_v[i][i]) begin
                chk("out_op", i, {30'b0, w_op[i]}, {30'b0, m_op[i][i]});
                chk("out_result", i, w_res[i], m_res[i][i]);
            end
        end
    endtask

    // Drive one cycle, advance the model across the coming edge, then check
    // the outputs at the following falling edge.
    task automatic step(input logic v, input logic [1:0] o, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic e, input logic f);
        vin = v; op = o; s1 = a; s2 = b; en = e; flush = f;
        for (int i = 0; i < NL; i++) begin
            if (f) begin
                for (int k = 0; k <= i; k++) m_v[i][k] = 1'b0;
            end else if (e) begin
                for (int k = i; k >= 1; k--) begin
                    m_v[i][k]   = m_v[i][k-1];
                    m_op[i][k]  = m_op[i][k-1];
                    m_res[i][k] = m_res[i][k-1];
                end
                m_v[i][0]   = v;
                m_op[i][0]  = o;
                m_res[i][0] = ref_mul(o, a, b);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic lit(input string name, input int inst, input logic v, input logic [1:0] o,
                       input logic [DW-1:0] r);
        chk({name, "_valid"}, inst, {31'b0, w_v[inst]}, {31'b0, v});
        if (v) begin
            chk({name, "_op"}, inst, {30'b0, w_op[inst]}, {30'b0, o});
            chk({name, "_res"}, inst, w_res[inst], r);
        end
    endtask

    task automatic bubble();
        step(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
    endtask

    function automatic logic [DW-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; vin = 1'b0; op = '0; s1 = '0; s2 = '0;
        model_clear();

        // model pins
        chk("pin_mul",    0, ref_mul(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0001);
        chk("pin_mulh",   0, ref_mul(2'd1, 32'h8000_0000, 32'h0000_0002), 32'hFFFF_FFFF);
        chk("pin_mulhsu", 0, ref_mul(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("pin_mulhu",  0, ref_mul(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

        // reset values
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            chk("rst_valid", i, {31'b0, w_v[i]}, 32'd0);
            chk("rst_op", i, {30'b0, w_op[i]}, 32'd0);
            chk("rst_res", i, w_res[i], 32'd0);
        end
        rst = 1'b0;

        // all four ops on all-ones operands, back to back
        step(1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        lit("ones_early", 1, 1'b0, 2'd0, '0);
        step(1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        lit("ones_mul", 1, 1'b1, 2'd0, 32'h0000_0001);
        step(1'b1, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        lit("ones_mulh", 1, 1'b1, 2'd1, 32'h0000_0000);
        step(1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        lit("ones_mulhsu", 1, 1'b1, 2'd2, 32'hFFFF_FFFF);
        bubble();
        lit("ones_mulhu", 1, 1'b1, 2'd3, 32'hFFFF_FFFE);
        bubble();
        lit("ones_drain", 1, 1'b0, 2'd0, '0);
        bubble(); bubble();

        // most-negative operand corners
        step(1'b1, 2'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        step(1'b1, 2'd3, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        lit("min_mulh", 1, 1'b1, 2'd1, 32'h4000_0000);
        step(1'b1, 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        lit("min_mulhu", 1, 1'b1, 2'd3, 32'h4000_0000);
        step(1'b1, 2'd1, 32'h8000_0000, 32'h0000_0002, 1'b1, 1'b0);
        lit("min_mul", 1, 1'b1, 2'd0, 32'h0000_0000);
        bubble();
        lit("min_x2_mulh", 1, 1'b1, 2'd1, 32'hFFFF_FFFF);
        bubble(); bubble(); bubble();

        // stall mid-flight, then stall with the result on the output
        step(1'b1, 2'd0, 32'h0001_2345, 32'h0000_0010, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'd3, $urandom, $urandom, 1'b0, 1'b0);
            lit("stall_a", 1, 1'b0, 2'd0, '0);
        end
        bubble();
        lit("stall_res", 1, 1'b1, 2'd0, 32'h0012_3450);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'd1, $urandom, $urandom, 1'b0, 1'b0);
            lit("stall_hold", 1, 1'b1, 2'd0, 32'h0012_3450);
        end
        bubble();
        lit("stall_after", 1, 1'b0, 2'd0, '0);
        bubble(); bubble(); bubble();

        // flush with a same-cycle op, then flush during a stall
        for (int k = 0; k < 3; k++) step(1'b1, 2'(k), rand_opnd(), rand_opnd(), 1'b1, 1'b0);
        step(1'b1, 2'd0, 32'd7, 32'd9, 1'b1, 1'b1);
        lit("flush", 3, 1'b0, 2'd0, '0);
        for (int k = 0; k < 4; k++) begin
            bubble();
            lit("flush_quiet", 3, 1'b0, 2'd0, '0);
        end
        for (int k = 0; k < 3; k++) step(1'b1, 2'(k + 1), rand_opnd(), rand_opnd(), 1'b1, 1'b0);
        step(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 32'd7, 32'd9, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            bubble();
            lit("stall_flush", 3, 1'b0, 2'd0, '0);
        end

        // asynchronous reset between edges with ops in flight
        step(1'b1, 2'd3, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
        step(1'b1, 2'd2, 32'h8765_4321, 32'hFFFF_FFFF, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NL; i++) begin
            chk("arst_valid", i, {31'b0, w_v[i]}, 32'd0);
            chk("arst_op", i, {30'b0, w_op[i]}, 32'd0);
            chk("arst_res", i, w_res[i], 32'd0);
        end
        #1 rst = 1'b0;
        model_clear();
        step(1'b1, 2'd0, 32'd3, 32'd5, 1'b1, 1'b0);
        bubble();
        lit("post_rst", 1, 1'b1, 2'd0, 32'd15);
        bubble(); bubble(); bubble();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(),
                 $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
